// File: rtl/uart_status_tx.sv
// UART 8N1 status transmitter: on a request, snapshots the LED vector and sends
// the 14-byte ASCII line "LED=xxxxxxxx\r\n", with LED8 first.
module uart_status_tx #(
    parameter int CLOCK_RATE = 50_000_000,
    parameter int BAUD_RATE  = 1_000_000
) (
    input  logic       i_Clock,
    input  logic       i_Rst,
    input  logic       i_Req,
    input  logic [7:0] i_LEDs,
    output logic       o_TXD,
    output logic       o_Busy,
    output logic       o_Done
);

    localparam int          CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE;
    localparam logic [15:0] BIT_LAST     = 16'(CLKS_PER_BIT - 1);
    localparam logic [3:0]  LAST_BYTE    = 4'd13;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state, state_nxt;
    logic [15:0] bit_cnt, bit_cnt_nxt;
    logic [2:0]  bit_idx, bit_idx_nxt;
    logic [3:0]  byte_idx, byte_idx_nxt;
    logic [7:0]  snapshot, snapshot_nxt;
    logic        txd_nxt, busy_nxt, done_nxt;
    logic [7:0]  cur_byte;
    logic [2:0]  led_sel;
    logic [2:0]  bit_idx_inc;

    // Index 4 carries LED8 (snapshot[7]), index 11 carries LED1 (snapshot[0]).
    assign led_sel     = 3'(4'd11 - byte_idx);
    assign bit_idx_inc = bit_idx + 3'd1;

    always_comb begin
        cur_byte = 8'h30;
        case (byte_idx)
            4'd0:    cur_byte = 8'h4C;
            4'd1:    cur_byte = 8'h45;
            4'd2:    cur_byte = 8'h44;
            4'd3:    cur_byte = 8'h3D;
            4'd12:   cur_byte = 8'h0D;
            4'd13:   cur_byte = 8'h0A;
            default: cur_byte = snapshot[led_sel] ? 8'h31 : 8'h30;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Rst) begin
            state    <= IDLE;
            bit_cnt  <= 16'd0;
            bit_idx  <= 3'd0;
            byte_idx <= 4'd0;
            snapshot <= 8'd0;
            o_TXD    <= 1'b1;
            o_Busy   <= 1'b0;
            o_Done   <= 1'b0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_cnt_nxt;
            bit_idx  <= bit_idx_nxt;
            byte_idx <= byte_idx_nxt;
            snapshot <= snapshot_nxt;
            o_TXD    <= txd_nxt;
            o_Busy   <= busy_nxt;
            o_Done   <= done_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        bit_idx_nxt  = bit_idx;
        byte_idx_nxt = byte_idx;
        snapshot_nxt = snapshot;
        txd_nxt      = o_TXD;
        busy_nxt     = o_Busy;
        done_nxt     = 1'b0;

        case (state)
            IDLE: begin
                txd_nxt = 1'b1;
                if (i_Req) begin
                    snapshot_nxt = i_LEDs;
                    byte_idx_nxt = 4'd0;
                    bit_cnt_nxt  = 16'd0;
                    state_nxt    = START;
                    txd_nxt      = 1'b0;
                    busy_nxt     = 1'b1;
                end
            end
            START: begin
                if (bit_cnt == BIT_LAST) begin
                    bit_cnt_nxt = 16'd0;
                    bit_idx_nxt = 3'd0;
                    state_nxt   = DATA;
                    txd_nxt     = cur_byte[0];
                end else begin
                    bit_cnt_nxt = bit_cnt + 16'd1;
                end
            end
            DATA: begin
                if (bit_cnt == BIT_LAST) begin
                    bit_cnt_nxt = 16'd0;
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                        txd_nxt   = 1'b1;
                    end else begin
                        bit_idx_nxt = bit_idx_inc;
                        txd_nxt     = cur_byte[bit_idx_inc];
                    end
                end else begin
                    bit_cnt_nxt = bit_cnt + 16'd1;
                end
            end
            STOP: begin
                if (bit_cnt == BIT_LAST) begin
                    bit_cnt_nxt = 16'd0;
                    if (byte_idx == LAST_BYTE) begin
                        state_nxt = IDLE;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        txd_nxt   = 1'b1;
                    end else begin
                        // Next start bit follows the stop bit with no idle gap.
                        byte_idx_nxt = byte_idx + 4'd1;
                        state_nxt    = START;
                        txd_nxt      = 1'b0;
                    end
                end else begin
                    bit_cnt_nxt = bit_cnt + 16'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_status_tx.sv
// Directed bench for uart_status_tx: decodes o_TXD bit by bit against the
// expected ASCII status line and checks busy/done timing.
module tb_uart_status_tx;

    logic       i_Clock = 1'b0;
    logic       i_Rst;
    logic       i_Req;
    logic [7:0] i_LEDs;
    logic       o_TXD;
    logic       o_Busy;
    logic       o_Done;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];

    uart_status_tx #(.CLOCK_RATE(50_000_000), .BAUD_RATE(1_000_000)) dut (
        .i_Clock(i_Clock),
        .i_Rst  (i_Rst),
        .i_Req  (i_Req),
        .i_LEDs (i_LEDs),
        .o_TXD  (o_TXD),
        .o_Busy (o_Busy),
        .o_Done (o_Done)
    );

    always #5 i_Clock = ~i_Clock;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic [7:0] leds, input int idx);
        case (idx)
            0:       return 8'h4C;
            1:       return 8'h45;
            2:       return 8'h44;
            3:       return 8'h3D;
            12:      return 8'h0D;
            13:      return 8'h0A;
            default: return leds[11 - idx] ? 8'h31 : 8'h30;
        endcase
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic req(input logic [7:0] leds);
        i_LEDs = leds;
        i_Req  = 1'b1;
        @(negedge i_Clock);
        i_Req  = 1'b0;
        check("txd_fall", o_TXD, 1'b0);
        check("busy_rise", o_Busy, 1'b1);
    endtask

    // Samples every cycle of one message (140 bits x 50 cycles). Ends at the
    // negedge where o_Done must be high, unless aborted by reset at abort_at.
    task automatic rx_msg(input logic [7:0] leds, input int poke_at, input int abort_at);
        logic [7:0] data;
        logic       first, mid;
        int         glitches, busy_hi, done_early, s;
        for (int i = 0; i < 14; i++) exp_q.push_back(exp_byte(leds, i));
        glitches = 0; busy_hi = 0; done_early = 0; s = 0; data = 8'h00;
        first = 1'b0; mid = 1'b0;
        for (int b = 0; b < 14; b++) begin
            for (int k = 0; k < 10; k++) begin
                for (int c = 0; c < 50; c++) begin
                    if (s == abort_at) begin
                        i_Rst = 1'b1;
                        @(negedge i_Clock);
                        check("abort_txd", o_TXD, 1'b1);
                        check("abort_busy", o_Busy, 1'b0);
                        check("abort_done", o_Done, 1'b0);
                        i_Rst = 1'b0;
                        exp_q.delete();
                        return;
                    end
                    if (c == 0) first = o_TXD;
                    else if (o_TXD !== first) glitches++;
                    if (c == 25) mid = o_TXD;
                    if (o_Busy === 1'b1) busy_hi++;
                    if (o_Done !== 1'b0) done_early++;
                    if (s == poke_at) begin
                        i_LEDs = 8'hF0;
                        i_Req  = 1'b1;
                    end else if (s == poke_at + 1) begin
                        i_Req = 1'b0;
                    end
                    s++;
                    @(negedge i_Clock);
                end
                if (k == 0)      check("start_bit", mid, 1'b0);
                else if (k == 9) check("stop_bit", mid, 1'b1);
                else             data[k-1] = mid;
            end
            check($sformatf("byte%0d", b), data, exp_q.pop_front());
        end
        check("bit_glitches", glitches, 0);
        check("busy_cycles", busy_hi, 7000);
        check("done_early", done_early, 0);
        check("done_pulse", o_Done, 1'b1);
        check("done_busy", o_Busy, 1'b0);
        check("done_txd", o_TXD, 1'b1);
    endtask

    // Line must stay idle: no busy, no done, TXD high.
    task automatic idle_watch(input string tag, input int n);
        int bad;
        bad = 0;
        repeat (n) begin
            @(negedge i_Clock);
            if (o_Busy !== 1'b0 || o_Done !== 1'b0 || o_TXD !== 1'b1) bad++;
        end
        check(tag, bad, 0);
    endtask

    initial begin
        i_Rst  = 1'b1;
        i_Req  = 1'b1;
        i_LEDs = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_Clock);
            check("rst_txd", o_TXD, 1'b1);
            check("rst_busy", o_Busy, 1'b0);
            check("rst_done", o_Done, 1'b0);
        end
        i_Rst = 1'b0;
        i_Req = 1'b0;
        idle_watch("post_reset_idle", 20);

        // Single request
        req(8'b1000_0001);
        rx_msg(8'b1000_0001, -1, -1);
        idle_watch("single_idle", 200);

        // Snapshot isolation and ignored request while busy
        req(8'h0F);
        rx_msg(8'h0F, 1000, -1);
        idle_watch("no_second_msg", 200);

        // Back-to-back: request during the done cycle
        req(8'h55);
        rx_msg(8'h55, -1, -1);
        req(8'hAA);
        rx_msg(8'hAA, -1, -1);
        idle_watch("b2b_idle", 50);

        // Reset mid-message, then a clean message
        req(8'h3C);
        rx_msg(8'h3C, -1, 2500);
        idle_watch("after_abort_idle", 100);
        req(8'h5A);
        rx_msg(8'h5A, -1, -1);
        idle_watch("final_idle", 20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
